ofdm_symbol_sequencer: RTL
==========================

Name: ofdm_symbol_sequencer

Overview:
- Sits directly in front of the FFT demodulator. It annotates the time-synchronised baseband sample stream with OFDM symbol timing.
- Per sample it produces the tuser word {sfn, subframe, symbol, cp_len} and a tlast on the final sample of every symbol (CP + FFT_LEN samples).
- A sync pulse from the PSS/PBCH chain loads the counters. The block then free-runs through symbols, slots and frames until the next sync.

Parameters:
- IN_DW, 32, sample width ({im, re}), passed through unchanged.
- NFFT, 8, log2 of FFT length; FFT_LEN = 2**NFFT.
- SYM_PER_SF, 14, symbols per slot.
- SUBFRAMES_PER_FRAME, 20, slots per frame (30 kHz SCS).
- SFN_MAX, 1023, last system frame number.
- Derived (localparam): CP1 = 20*FFT_LEN/256 (long CP), CP2 = 18*FFT_LEN/256.
- Derived widths: SFN_WIDTH = clog2(SFN_MAX), SUBFRAME_NUMBER_WIDTH = clog2(SUBFRAMES_PER_FRAME-1), SYMBOL_NUMBER_WIDTH = clog2(SYM_PER_SF-1), CP_WIDTH = clog2(CP1).
- Derived: USER_WIDTH = SFN_WIDTH + SUBFRAME_NUMBER_WIDTH + SYMBOL_NUMBER_WIDTH + CP_WIDTH.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- s_axis_in_tdata  in  IN_DW  input sample
- s_axis_in_tvalid  in  1  sample valid; no backpressure
- sync_i  in  1  qualified by tvalid: the current sample is CP sample 0 of the symbol given below
- sync_sfn_i  in  SFN_WIDTH  SFN loaded at sync
- sync_subframe_i  in  SUBFRAME_NUMBER_WIDTH  slot number loaded at sync
- sync_symbol_i  in  SYMBOL_NUMBER_WIDTH  symbol number loaded at sync
- m_axis_out_tdata  out  IN_DW  registered sample
- m_axis_out_tuser  out  USER_WIDTH  {sfn, subframe, symbol, cp_len}, cp_len in LSBs
- m_axis_out_tlast  out  1  last sample of symbol
- m_axis_out_tvalid  out  1  output valid
- symbol_start_o  out  1  pulse with first sample (CP sample 0) of each symbol
- locked_o  out  1  high once the first sync has been accepted

Behaviour:
- Reset (async assert, synchronous-safe deassert):
  - All outputs 0, state IDLE, counters 0, locked_o = 0.
- States:
  - IDLE: samples are dropped (tvalid_out = 0). tvalid && sync_i -> TRACK.
  - TRACK: every valid input produces exactly one valid output, 1 cycle later. There is no other exit; only reset returns to IDLE.
- sync_i without s_axis_in_tvalid is ignored.
- Accepted sync (either state):
  - Load sfn, subframe and symbol from the sync inputs.
  - Set sample_cnt to 0. The current sample is emitted as CP sample 0 with the loaded labels and symbol_start_o = 1.
- cp_len = CP1 when symbol == 0, else CP2.
- sym_len = cp_len + FFT_LEN.
- sample_cnt advances only on valid samples; invalid cycles hold all counters and give tvalid_out = 0.
- tlast = 1 when sample_cnt == sym_len - 1. On that sample, sample_cnt -> 0 and the symbol counter advances.
- Counter wraps:
  - symbol: SYM_PER_SF-1 -> 0, subframe +1.
  - subframe: SUBFRAMES_PER_FRAME-1 -> 0, sfn +1.
  - sfn: SFN_MAX -> 0.
- tuser carries the labels of the symbol the sample belongs to, including on its tlast sample. The rollover takes effect on the next sample.
- Sync in the middle of a symbol: the truncated symbol gets no tlast. The new symbol starts at the sync sample. A sync coinciding with a natural tlast sample overrides it: that output has tlast = 0 and symbol_start_o = 1.
- Throughput: 1 sample/clk. Latency: exactly 1 clk; tdata is bit-exact.

Test Plan:
1. NFFT=8. Reset, then a continuous valid stream with no sync -> tvalid_out stays 0 and locked_o = 0.
2. Sync with sfn=5, subframe=0, symbol=0, then a continuous stream:
   - first tlast on output sample 275 (CP1=20 + 256), tuser cp_len=20, symbol=0;
   - next tlast 274 samples later with cp_len=18, symbol=1;
   - a slot spans 3838 samples.
3. Sync with sfn=1023, subframe=19, symbol=13 -> after 274 samples, tuser = {sfn 0, subframe 0, symbol 0, cp_len 20} and symbol_start_o pulses.
4. Random tvalid gaps (50% duty) -> output sequence equals the gap-free case when gaps are removed; counters hold during gaps.
5. Sync at sample 100 of symbol 3, loading symbol=7 -> no tlast for symbol 3; the next tlast arrives 273 samples after the sync sample, with symbol=7.
6. Assert reset_ni low for 1 clk mid-symbol -> all outputs 0 immediately (async). Valid samples are dropped until a new sync.

Source files
------------

// File: rtl/ofdm_symbol_sequencer.sv
// ofdm_symbol_sequencer: labels a time-synchronised sample stream with OFDM symbol timing
// (tuser {sfn, subframe, symbol, cp_len}, tlast per symbol). Revision: 1.0
`default_nettype none

module ofdm_symbol_sequencer #(
   parameter int IN_DW               = 32,
   parameter int NFFT                = 8,
   parameter int SYM_PER_SF          = 14,
   parameter int SUBFRAMES_PER_FRAME = 20,
   parameter int SFN_MAX             = 1023,
   localparam int FFT_LEN               = 2**NFFT,
   localparam int CP1                   = 20*FFT_LEN/256,
   localparam int CP2                   = 18*FFT_LEN/256,
   localparam int SFN_WIDTH             = $clog2(SFN_MAX),
   localparam int SUBFRAME_NUMBER_WIDTH = $clog2(SUBFRAMES_PER_FRAME-1),
   localparam int SYMBOL_NUMBER_WIDTH   = $clog2(SYM_PER_SF-1),
   localparam int CP_WIDTH              = $clog2(CP1),
   localparam int USER_WIDTH            = SFN_WIDTH + SUBFRAME_NUMBER_WIDTH
                                          + SYMBOL_NUMBER_WIDTH + CP_WIDTH
) (
   input  logic                             clk_i,
   input  logic                             reset_ni,
   input  logic [IN_DW-1:0]                 s_axis_in_tdata,
   input  logic                             s_axis_in_tvalid,
   input  logic                             sync_i,
   input  logic [SFN_WIDTH-1:0]             sync_sfn_i,
   input  logic [SUBFRAME_NUMBER_WIDTH-1:0] sync_subframe_i,
   input  logic [SYMBOL_NUMBER_WIDTH-1:0]   sync_symbol_i,
   output logic [IN_DW-1:0]                 m_axis_out_tdata,
   output logic [USER_WIDTH-1:0]            m_axis_out_tuser,
   output logic                             m_axis_out_tlast,
   output logic                             m_axis_out_tvalid,
   output logic                             symbol_start_o,
   output logic                             locked_o
);

   localparam int CNT_WIDTH = $clog2(CP1 + FFT_LEN);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t                           state_q;
   logic [SFN_WIDTH-1:0]             sfn_q, sfn_d, lbl_sfn;
   logic [SUBFRAME_NUMBER_WIDTH-1:0] sub_q, sub_d, lbl_sub;
   logic [SYMBOL_NUMBER_WIDTH-1:0]   sym_q, sym_d, lbl_sym;
   logic [CNT_WIDTH-1:0]             cnt_q, cnt_d, lbl_cnt, last_cnt;
   logic [CP_WIDTH-1:0]              lbl_cp;
   logic                             load, accept, is_last;

   logic [IN_DW-1:0]      tdata_q;
   logic [USER_WIDTH-1:0] tuser_q;
   logic                  tlast_q, tvalid_q, start_q, locked_q;

   // Labels of the current input sample: a qualified sync overrides the running counters.
   always_comb begin
      load     = s_axis_in_tvalid && sync_i;
      accept   = s_axis_in_tvalid && ((state_q == TRACK) || sync_i);
      lbl_sfn  = load ? sync_sfn_i      : sfn_q;
      lbl_sub  = load ? sync_subframe_i : sub_q;
      lbl_sym  = load ? sync_symbol_i   : sym_q;
      lbl_cnt  = load ? '0              : cnt_q;
      lbl_cp   = (lbl_sym == '0) ? CP_WIDTH'(CP1) : CP_WIDTH'(CP2);
      last_cnt = CNT_WIDTH'(FFT_LEN - 1) + CNT_WIDTH'(lbl_cp);
      is_last  = !load && (lbl_cnt == last_cnt);

      sfn_d = lbl_sfn;
      sub_d = lbl_sub;
      sym_d = lbl_sym;
      cnt_d = lbl_cnt + CNT_WIDTH'(1);
      if (is_last) begin
         cnt_d = '0;
         if (lbl_sym == SYMBOL_NUMBER_WIDTH'(SYM_PER_SF - 1)) begin
            sym_d = '0;
            if (lbl_sub == SUBFRAME_NUMBER_WIDTH'(SUBFRAMES_PER_FRAME - 1)) begin
               sub_d = '0;
               sfn_d = (lbl_sfn == SFN_WIDTH'(SFN_MAX)) ? '0 : lbl_sfn + SFN_WIDTH'(1);
            end else begin
               sub_d = lbl_sub + SUBFRAME_NUMBER_WIDTH'(1);
            end
         end else begin
            sym_d = lbl_sym + SYMBOL_NUMBER_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         sfn_q    <= '0;
         sub_q    <= '0;
         sym_q    <= '0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tuser_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         start_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         tvalid_q <= accept;
         tlast_q  <= accept && is_last;
         start_q  <= accept && (lbl_cnt == '0);
         if (accept) begin
            state_q  <= TRACK;
            locked_q <= 1'b1;
            tdata_q  <= s_axis_in_tdata;
            tuser_q  <= {lbl_sfn, lbl_sub, lbl_sym, lbl_cp};
            sfn_q    <= sfn_d;
            sub_q    <= sub_d;
            sym_q    <= sym_d;
            cnt_q    <= cnt_d;
         end
      end
   end

   assign m_axis_out_tdata  = tdata_q;
   assign m_axis_out_tuser  = tuser_q;
   assign m_axis_out_tlast  = tlast_q;
   assign m_axis_out_tvalid = tvalid_q;
   assign symbol_start_o    = start_q;
   assign locked_o          = locked_q;

endmodule

`default_nettype wire
